// File: rtl/t04_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package t04_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    // addi x0,x0,0 : harmless instruction presented after reset or a dropped fetch
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/t04_fetch_watchdog.sv
// Bus wait-state watchdog: counts enabled cycles since the last clear and
// flags expiry on the enabled cycle that brings the count to TIMEOUT.
module t04_fetch_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    // Saturating wait-cycle counter; never wraps back to zero on its own
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Expire on the cycle whose increment would reach TIMEOUT
    assign expired = enable && (count_reg >= LAST);

endmodule

// File: rtl/t04_instruction_fetch.sv
// Instruction fetch unit: turns the PC value into an instruction-memory read,
// captures the returned word and pulses pcEnable so the PC can advance.
module t04_instruction_fetch
    import t04_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT)
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [ADDR_W-1:0] instructionAddress,
    input  logic              stall,
    input  logic              flush,
    output logic              busRead,
    output logic [ADDR_W-1:0] busAddr,
    input  logic              busAck,
    input  logic [DATA_W-1:0] busRdata,
    output logic [DATA_W-1:0] instruction,
    output logic              instrValid,
    output logic              pcEnable,
    output logic              fetchErr
);

    fetch_state_t      state_reg, state_next;
    logic              bus_read_reg, bus_read_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [DATA_W-1:0] instruction_reg, instruction_next;
    logic              fetch_err_reg, fetch_err_next;
    logic              discard_reg, discard_next;
    logic              timer_clear, timer_enable, timer_expired;

    t04_fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .nRst    (nRst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg       <= IDLE;
            bus_read_reg    <= 1'b0;
            bus_addr_reg    <= '0;
            instruction_reg <= NOP_INSTR;
            fetch_err_reg   <= 1'b0;
            discard_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bus_read_reg    <= bus_read_next;
            bus_addr_reg    <= bus_addr_next;
            instruction_reg <= instruction_next;
            fetch_err_reg   <= fetch_err_next;
            discard_reg     <= discard_next;
        end
    end

    // Next-state logic plus the combinational DONE-state handshake outputs
    always_comb begin
        state_next       = state_reg;
        bus_read_next    = bus_read_reg;
        bus_addr_next    = bus_addr_reg;
        instruction_next = instruction_reg;
        fetch_err_next   = fetch_err_reg;
        discard_next     = discard_reg;
        timer_clear      = 1'b0;
        timer_enable     = 1'b0;
        instrValid       = 1'b0;
        pcEnable         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!stall) begin
                    if (instructionAddress[1:0] == 2'b00) begin
                        bus_addr_next = instructionAddress;
                        bus_read_next = 1'b1;
                        timer_clear   = 1'b1;
                        state_next    = WAIT;
                    end else begin
                        // Misaligned PC: never touch the bus
                        fetch_err_next = 1'b1;
                        state_next     = ERR;
                    end
                end
            end
            WAIT: begin
                if (busAck) begin
                    bus_read_next = 1'b0;
                    if (discard_reg || flush) begin
                        // Fetch belonged to the wrong path: drop it silently
                        instruction_next = NOP_INSTR;
                        discard_next     = 1'b0;
                        state_next       = IDLE;
                    end else begin
                        instruction_next = busRdata;
                        state_next       = DONE;
                    end
                end else begin
                    timer_enable = 1'b1;
                    // The bus cycle cannot be aborted, so remember to drop it later
                    if (flush) begin
                        discard_next = 1'b1;
                    end
                    if (timer_expired) begin
                        fetch_err_next = 1'b1;
                        bus_read_next  = 1'b0;
                        state_next     = ERR;
                    end
                end
            end
            DONE: begin
                instrValid = !flush;
                pcEnable   = !stall && !flush;
                if (flush || !stall) begin
                    state_next = IDLE;
                end
            end
            ERR: begin
                // Terminal until reset
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busRead     = bus_read_reg;
    assign busAddr     = bus_addr_reg;
    assign instruction = instruction_reg;
    assign fetchErr    = fetch_err_reg;

endmodule

// File: tb/tb_t04_instruction_fetch.sv
// Directed bench for t04_instruction_fetch: table of clean fetches plus
// hand-written sequences for reset, stall, flush, timeout and misalignment.
module tb_t04_instruction_fetch;

    localparam int TOUT = 4;

    logic        clk = 1'b0;
    logic        nRst;
    logic [31:0] instructionAddress;
    logic        stall;
    logic        flush;
    logic        busRead;
    logic [31:0] busAddr;
    logic        busAck;
    logic [31:0] busRdata;
    logic [31:0] instruction;
    logic        instrValid;
    logic        pcEnable;
    logic        fetchErr;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] addr;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [5];

    t04_instruction_fetch #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TOUT)
    ) dut (
        .clk                (clk),
        .nRst               (nRst),
        .instructionAddress (instructionAddress),
        .stall              (stall),
        .flush              (flush),
        .busRead            (busRead),
        .busAddr            (busAddr),
        .busAck             (busAck),
        .busRdata           (busRdata),
        .instruction        (instruction),
        .instrValid         (instrValid),
        .pcEnable           (pcEnable),
        .fetchErr           (fetchErr)
    );

    always #5 clk = ~clk;

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Asynchronous reset mid-cycle, checked while held
    task automatic do_reset(input string tag);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        chk({tag, "_busRead"},     busRead,     0);
        chk({tag, "_busAddr"},     busAddr,     0);
        chk({tag, "_instruction"}, instruction, 32'h13);
        chk({tag, "_instrValid"},  instrValid,  0);
        chk({tag, "_pcEnable"},    pcEnable,    0);
        chk({tag, "_fetchErr"},    fetchErr,    0);
        @(negedge clk);
        nRst = 1'b1;
        $display("reset %s", tag);
    endtask

    // Let IDLE issue a request; returns at the first WAIT negedge (+1) with stall=1
    task automatic start_req(input logic [31:0] a, input string tag);
        @(negedge clk);
        instructionAddress = a;
        stall  = 1'b0;
        busAck = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        #1;
        chk({tag, "_req_busRead"}, busRead, 1);
        chk({tag, "_req_busAddr"}, busAddr, a);
    endtask

    // Full clean fetch with d wait cycles before busAck
    task automatic fetch(input logic [31:0] a, input int d, input logic [31:0] rd,
                         input logic [31:0] exp, input string tag);
        int bad;
        bad = 0;
        start_req(a, tag);
        for (int i = 0; i <= d; i++) begin
            if (i > 0) @(negedge clk);
            busAck   = (i == d);
            busRdata = (i == d) ? rd : (32'hBAD0_0000 + 32'(i));
            stall    = (i == d) ? 1'b0 : 1'b1;
            #1;
            if (busRead !== 1'b1 || busAddr !== a || instrValid !== 1'b0 || pcEnable !== 1'b0)
                bad++;
        end
        chk({tag, "_wait_hold"}, 32'(bad), 0);
        @(negedge clk);
        busAck = 1'b0;
        #1;
        chk({tag, "_instruction"}, instruction, exp);
        chk({tag, "_instrValid"},  instrValid,  1);
        chk({tag, "_pcEnable"},    pcEnable,    1);
        chk({tag, "_busRead_done"}, busRead,    0);
        @(negedge clk);
        stall = 1'b1;
        #1;
        chk({tag, "_pcEnable_once"}, pcEnable,   0);
        chk({tag, "_valid_drop"},    instrValid, 0);
        $display("fetch %s addr=%h delay=%0d instr=%h", tag, a, d, instruction);
    endtask

    initial begin
        int bad;
        int pulses;

        vecs[0] = '{32'h0000_0010, 2, 32'h00A0_0093, 32'h00A0_0093};
        vecs[1] = '{32'h0000_0014, 0, 32'h0010_0113, 32'h0010_0113};
        vecs[2] = '{32'h0000_0018, 1, 32'hFFF0_0193, 32'hFFF0_0193};
        vecs[3] = '{32'h0000_001C, 3, 32'h4000_0033, 32'h4000_0033};
        vecs[4] = '{32'hFFFF_FFFC, 0, 32'h1234_5678, 32'h1234_5678};

        nRst = 1'b0;
        instructionAddress = '0;
        stall = 1'b1;
        flush = 1'b0;
        busAck = 1'b0;
        busRdata = '0;

        // Power-on reset state
        repeat (2) @(negedge clk);
        #1;
        chk("por_busRead",     busRead,     0);
        chk("por_busAddr",     busAddr,     0);
        chk("por_instruction", instruction, 32'h13);
        chk("por_instrValid",  instrValid,  0);
        chk("por_pcEnable",    pcEnable,    0);
        chk("por_fetchErr",    fetchErr,    0);
        @(negedge clk);
        nRst = 1'b1;
        $display("reset por");

        // Table of clean fetches
        for (int v = 0; v < 5; v++) begin
            fetch(vecs[v].addr, vecs[v].delay, vecs[v].rdata, vecs[v].exp_instr,
                  $sformatf("vec%0d", v));
        end

        // Reset asserted in the middle of a WAIT
        start_req(32'h80, "rstw");
        @(negedge clk);
        nRst = 1'b0;
        #1;
        chk("rstw_busRead",     busRead,     0);
        chk("rstw_instruction", instruction, 32'h13);
        chk("rstw_fetchErr",    fetchErr,    0);
        chk("rstw_instrValid",  instrValid,  0);
        @(negedge clk);
        nRst = 1'b1;
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (busRead !== 1'b0) bad++;
        end
        chk("rstw_idle_after", 32'(bad), 0);
        $display("reset mid-wait");
        fetch(32'h84, 0, 32'h0050_0393, 32'h0050_0393, "post_rst");

        // Stall in IDLE blocks requests
        bad = 0;
        instructionAddress = 32'h20;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (busRead !== 1'b0) bad++;
        end
        chk("stall_idle_noreq", 32'(bad), 0);
        $display("stall idle 5 cycles");

        // Stall in DONE: instrValid held, pcEnable withheld, then a single pulse
        start_req(32'h20, "sdone");
        busAck = 1'b1;
        busRdata = 32'h0020_0213;
        @(negedge clk);
        busAck = 1'b0;
        #1;
        chk("sdone_valid",  instrValid,  1);
        chk("sdone_pcen0",  pcEnable,    0);
        chk("sdone_instr",  instruction, 32'h0020_0213);
        bad = 0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (instrValid !== 1'b1) bad++;
            if (pcEnable !== 1'b0) pulses++;
        end
        chk("sdone_hold_valid", 32'(bad), 0);
        @(negedge clk);
        stall = 1'b0;
        #1;
        if (pcEnable === 1'b1) pulses++;
        chk("sdone_release_pcen", pcEnable, 1);
        @(negedge clk);
        stall = 1'b1;
        #1;
        if (pcEnable !== 1'b0) pulses++;
        chk("sdone_pulses", 32'(pulses), 1);
        $display("stall in done instr=%h", instruction);

        // Flush during WAIT, ack arrives three cycles later
        start_req(32'h30, "fwait");
        flush = 1'b1;
        instructionAddress = 32'h40;
        pulses = 0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        if (pcEnable !== 1'b0 || instrValid !== 1'b0) pulses++;
        @(negedge clk);
        #1;
        if (pcEnable !== 1'b0 || instrValid !== 1'b0) pulses++;
        @(negedge clk);
        busAck = 1'b1;
        busRdata = 32'hDEAD_BEEF;
        #1;
        chk("fwait_bus_held", busRead, 1);
        chk("fwait_addr_held", busAddr, 32'h30);
        @(negedge clk);
        busAck = 1'b0;
        #1;
        if (pcEnable !== 1'b0) pulses++;
        chk("fwait_instruction", instruction, 32'h13);
        chk("fwait_instrValid", instrValid, 0);
        chk("fwait_busRead", busRead, 0);
        chk("fwait_no_pcen", 32'(pulses), 0);
        $display("flush in wait instr=%h", instruction);
        fetch(32'h40, 0, 32'h0030_0293, 32'h0030_0293, "fwait_next");

        // busAck and flush in the same cycle: flush wins
        start_req(32'h50, "fack");
        busAck = 1'b1;
        flush = 1'b1;
        busRdata = 32'hCAFE_F00D;
        @(negedge clk);
        busAck = 1'b0;
        flush = 1'b0;
        #1;
        chk("fack_instruction", instruction, 32'h13);
        chk("fack_instrValid",  instrValid,  0);
        chk("fack_pcEnable",    pcEnable,    0);
        $display("flush with ack instr=%h", instruction);

        // Flush in DONE kills instrValid/pcEnable and returns to IDLE
        start_req(32'h60, "fdone");
        busAck = 1'b1;
        busRdata = 32'h0040_0313;
        @(negedge clk);
        busAck = 1'b0;
        flush = 1'b1;
        #1;
        chk("fdone_instrValid", instrValid, 0);
        chk("fdone_pcEnable",   pcEnable,   0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fdone_left_done", instrValid, 0);
        chk("fdone_busRead",   busRead,    0);
        $display("flush in done");

        // Timeout after TOUT wait cycles without busAck
        start_req(32'h70, "tout");
        chk("tout_err_early", fetchErr, 0);
        bad = 0;
        repeat (TOUT - 1) begin
            @(negedge clk);
            #1;
            if (busRead !== 1'b1 || fetchErr !== 1'b0) bad++;
        end
        chk("tout_wait_cycles", 32'(bad), 0);
        @(negedge clk);
        #1;
        chk("tout_fetchErr", fetchErr, 1);
        chk("tout_busRead",  busRead,  0);
        stall = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (busRead !== 1'b0 || pcEnable !== 1'b0 || fetchErr !== 1'b1) bad++;
        end
        chk("tout_terminal", 32'(bad), 0);
        stall = 1'b1;
        $display("timeout fetchErr=%b", fetchErr);
        do_reset("after_tout");

        // Misaligned address
        @(negedge clk);
        instructionAddress = 32'h12;
        stall = 1'b0;
        @(negedge clk);
        #1;
        chk("mis_fetchErr", fetchErr, 1);
        chk("mis_busRead",  busRead,  0);
        instructionAddress = 32'h14;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (busRead !== 1'b0 || pcEnable !== 1'b0 || fetchErr !== 1'b1) bad++;
        end
        chk("mis_sticky", 32'(bad), 0);
        stall = 1'b1;
        $display("misaligned fetchErr=%b", fetchErr);
        do_reset("after_mis");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
